// File: rtl/qpsk_symbol_feeder.sv
// qpsk_symbol_feeder
//   Buffers payload bytes in a small FIFO and feeds a QPSK modulator one
//   dibit per mod_req pulse. Each frame begins with an alternating
//   00/10 preamble. The payload bytes follow, sent MSB dibit first. A frame
//   ends after the byte flagged with tx_last.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   tx_data    : payload byte
//   tx_last    : tx_data is the final byte of its frame
//   tx_valid   : tx_data / tx_last valid
//   tx_ready   : FIFO not full (combinational)
//   mod_req    : modulator consumed the current symbol (one-cycle pulse)
//   symbol_out : registered symbol to the modulator
//   symbol_en  : registered; symbol_out is valid
//   busy       : FSM is not idle
//   underrun   : one-cycle pulse, FIFO empty when a mid-frame byte was needed
module qpsk_symbol_feeder #(
    parameter int FIFO_DEPTH   = 8,
    parameter int PREAMBLE_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       mod_req,
    output logic [1:0] symbol_out,
    output logic       symbol_en,
    output logic       busy,
    output logic       underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(PREAMBLE_LEN);
    localparam int DEPTH_I = FIFO_DEPTH;
    localparam int PRE_LAST_I = PREAMBLE_LEN - 1;
    localparam logic [AW:0]   DEPTH_C  = DEPTH_I[AW:0];
    localparam logic [PW-1:0] PRE_LAST = PRE_LAST_I[PW-1:0];

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

    // Dibit i of a byte, MSB first.
    function automatic logic [1:0] dibit_sel(input logic [7:0] b, input logic [1:0] i);
        case (i)
            2'd0:    dibit_sel = b[7:6];
            2'd1:    dibit_sel = b[5:4];
            2'd2:    dibit_sel = b[3:2];
            default: dibit_sel = b[1:0];
        endcase
    endfunction

    // FIFO: entries are {last, byte}; an occupancy counter gives full/empty.
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, empty, full;
    logic [8:0]    head;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign tx_ready = !full;
    assign push     = tx_valid && tx_ready;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {tx_last, tx_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM: all state and output registers advance only on mod_req edges.
    state_t        state, state_n;
    logic [PW-1:0] pre_cnt, pre_cnt_n;
    logic [1:0]    dibit_idx, dibit_idx_n;
    logic [8:0]    hold, hold_n;
    logic [1:0]    symbol_n;
    logic          symbol_en_n, underrun_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            dibit_idx  <= '0;
            hold       <= '0;
            symbol_out <= 2'b00;
            symbol_en  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            pre_cnt    <= pre_cnt_n;
            dibit_idx  <= dibit_idx_n;
            hold       <= hold_n;
            symbol_out <= symbol_n;
            symbol_en  <= symbol_en_n;
            underrun   <= underrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        pre_cnt_n   = pre_cnt;
        dibit_idx_n = dibit_idx;
        hold_n      = hold;
        symbol_n    = symbol_out;
        symbol_en_n = symbol_en;
        underrun_n  = 1'b0;
        pop         = 1'b0;
        if (mod_req) begin
            case (state)
                IDLE: begin
                    // Entering the preamble does not consume a byte.
                    if (!empty) begin
                        state_n     = PREAMBLE;
                        pre_cnt_n   = '0;
                        symbol_n    = 2'b00;
                        symbol_en_n = 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (pre_cnt != PRE_LAST) begin
                        pre_cnt_n = pre_cnt + PW'(1);
                        // The next index is odd when the current one is even.
                        symbol_n  = pre_cnt[0] ? 2'b00 : 2'b10;
                    end else if (!empty) begin
                        pop         = 1'b1;
                        hold_n      = head;
                        dibit_idx_n = 2'd0;
                        symbol_n    = head[7:6];
                        state_n     = DATA;
                    end else begin
                        underrun_n  = 1'b1;
                        symbol_n    = 2'b00;
                        symbol_en_n = 1'b0;
                        state_n     = IDLE;
                    end
                end
                DATA: begin
                    if (dibit_idx != 2'd3) begin
                        dibit_idx_n = dibit_idx + 2'd1;
                        symbol_n    = dibit_sel(hold[7:0], dibit_idx + 2'd1);
                    end else if (hold[8]) begin
                        symbol_n    = 2'b00;
                        symbol_en_n = 1'b0;
                        state_n     = IDLE;
                    end else if (!empty) begin
                        // Back-to-back bytes: no gap symbol between them.
                        pop         = 1'b1;
                        hold_n      = head;
                        dibit_idx_n = 2'd0;
                        symbol_n    = head[7:6];
                    end else begin
                        underrun_n  = 1'b1;
                        symbol_n    = 2'b00;
                        symbol_en_n = 1'b0;
                        state_n     = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_qpsk_symbol_feeder.sv
// Directed bench for qpsk_symbol_feeder (FIFO_DEPTH=8, PREAMBLE_LEN=16).
module tb_qpsk_symbol_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic       mod_req;
    logic [1:0] symbol_out;
    logic       symbol_en;
    logic       busy;
    logic       underrun;

    int vectors = 0;
    int miscompares = 0;
    bit keep_req = 1'b0;

    qpsk_symbol_feeder #(.FIFO_DEPTH(8), .PREAMBLE_LEN(16)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .mod_req(mod_req),
        .symbol_out(symbol_out), .symbol_en(symbol_en), .busy(busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One mod_req edge; in pulsed mode an idle cycle follows so the
    // subsequent checks also confirm the outputs hold without mod_req.
    task automatic adv();
        mod_req = 1'b1;
        step();
        if (!keep_req) begin
            mod_req = 1'b0;
            step();
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        tx_data = d; tx_last = l; tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin step(); n++; end
        if (!tx_ready) chk("push_timeout", {31'd0, tx_ready}, 32'd1);
        step();
        tx_valid = 1'b0;
    endtask

    task automatic run_preamble(input string tag);
        for (int k = 0; k < 16; k++) begin
            adv();
            chk({tag, "_pre_sym"}, {30'd0, symbol_out}, (k % 2 == 1) ? 32'd2 : 32'd0);
            chk({tag, "_pre_en"}, {31'd0, symbol_en}, 32'd1);
        end
    endtask

    initial begin
        logic [1:0] exp34 [8];
        exp34 = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};

        reset = 1'b0; tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b0; mod_req = 1'b0;
        #2;
        chk("rst_sym", {30'd0, symbol_out}, 32'd0);
        chk("rst_en", {31'd0, symbol_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_under", {31'd0, underrun}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        step();
        reset = 1'b1;
        step();

        // mod_req with no data stays idle
        for (int i = 0; i < 5; i++) begin
            adv();
            chk("nodata_en", {31'd0, symbol_en}, 32'd0);
            chk("nodata_busy", {31'd0, busy}, 32'd0);
            chk("nodata_ready", {31'd0, tx_ready}, 32'd1);
        end

        // Single-byte frame 0xB4
        push(8'hB4, 1'b1);
        chk("b4_idle_before", {31'd0, busy}, 32'd0);
        run_preamble("b4");
        chk("b4_busy", {31'd0, busy}, 32'd1);
        adv(); chk("b4_d0", {30'd0, symbol_out}, 32'd2);
        adv(); chk("b4_d1", {30'd0, symbol_out}, 32'd3);
        adv(); chk("b4_d2", {30'd0, symbol_out}, 32'd1);
        adv(); chk("b4_d3", {30'd0, symbol_out}, 32'd0);
        chk("b4_d3_en", {31'd0, symbol_en}, 32'd1);
        adv();
        chk("b4_end_en", {31'd0, symbol_en}, 32'd0);
        chk("b4_end_busy", {31'd0, busy}, 32'd0);
        chk("b4_end_sym", {30'd0, symbol_out}, 32'd0);

        // Two-byte frame with mod_req held high: one symbol per cycle
        push(8'h1B, 1'b0);
        push(8'hE4, 1'b1);
        keep_req = 1'b1;
        run_preamble("two");
        for (int i = 0; i < 8; i++) begin
            adv();
            chk("two_data", {30'd0, symbol_out}, {30'd0, exp34[i]});
            chk("two_en", {31'd0, symbol_en}, 32'd1);
        end
        adv();
        mod_req = 1'b0;
        keep_req = 1'b0;
        chk("two_end_en", {31'd0, symbol_en}, 32'd0);
        chk("two_end_busy", {31'd0, busy}, 32'd0);

        // Underrun after a non-last byte
        push(8'h55, 1'b0);
        run_preamble("ur");
        for (int i = 0; i < 4; i++) begin
            adv();
            chk("ur_data", {30'd0, symbol_out}, 32'd1);
        end
        mod_req = 1'b1;
        step();
        mod_req = 1'b0;
        chk("ur_pulse", {31'd0, underrun}, 32'd1);
        chk("ur_en", {31'd0, symbol_en}, 32'd0);
        chk("ur_busy", {31'd0, busy}, 32'd0);
        step();
        chk("ur_pulse_end", {31'd0, underrun}, 32'd0);

        // Fill the FIFO: 8 bytes accepted, 9th held off until the first pop
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_data = (i == 0) ? 8'hC6 : 8'h10 + 8'(i);
            tx_last = 1'b0;
            chk("fill_ready", {31'd0, tx_ready}, 32'd1);
            step();
        end
        tx_data = 8'h99; tx_last = 1'b1;
        chk("full_ready", {31'd0, tx_ready}, 32'd0);
        step(); step();
        chk("full_hold", {31'd0, tx_ready}, 32'd0);
        run_preamble("full");
        chk("full_after_pre", {31'd0, tx_ready}, 32'd0);
        mod_req = 1'b1;
        step();
        mod_req = 1'b0;
        chk("pop_ready", {31'd0, tx_ready}, 32'd1);
        chk("pop_sym", {30'd0, symbol_out}, 32'd3);
        step();
        tx_valid = 1'b0;
        chk("refull_ready", {31'd0, tx_ready}, 32'd0);

        // Reset in DATA with dibit_idx=2
        adv(); chk("c6_d1", {30'd0, symbol_out}, 32'd0);
        adv(); chk("c6_d2", {30'd0, symbol_out}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_sym", {30'd0, symbol_out}, 32'd0);
        chk("mid_rst_en", {31'd0, symbol_en}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("mid_rst_under", {31'd0, underrun}, 32'd0);
        step();
        reset = 1'b1;
        adv();
        chk("post_rst_empty_en", {31'd0, symbol_en}, 32'd0);
        push(8'hA5, 1'b1);
        adv();
        chk("post_rst_sym0", {30'd0, symbol_out}, 32'd0);
        chk("post_rst_en", {31'd0, symbol_en}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        adv();
        chk("post_rst_sym1", {30'd0, symbol_out}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qpsk_symbol_feeder.md
QPSK_SYMBOL_FEEDER -- requirements
Module: qpsk_symbol_feeder

Parameters
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning byte FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-002 The block SHALL have parameter PREAMBLE_LEN, default 16, meaning preamble symbols per frame; it SHALL be at least 2.

Interface
REQ-003 clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  8  payload byte.
REQ-006 tx_last  input  1  the byte on tx_data is the final byte of its frame.
REQ-007 tx_valid  input  1  tx_data and tx_last are valid.
REQ-008 tx_ready  output  1  the FIFO can accept a byte; combinational, equal to FIFO not full.
REQ-009 mod_req  input  1  one-cycle pulse from the modulator; the current symbol has been consumed.
REQ-010 symbol_out  output  2  symbol presented to the modulator; registered.
REQ-011 symbol_en  output  1  symbol_out is valid; when low, the modulator transmits its idle symbol; registered.
REQ-012 busy  output  1  high when the state is not IDLE.
REQ-013 underrun  output  1  one-cycle pulse; the FIFO was empty when a mid-frame byte was needed.

Function
REQ-014 A byte SHALL be pushed when tx_valid and tx_ready are both high; the FIFO entry SHALL store {tx_last, tx_data}.
REQ-015 A simultaneous push and pop SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 The FSM SHALL have the states IDLE, PREAMBLE and DATA; symbol_out, symbol_en and the state SHALL change only on an edge where mod_req is high.
REQ-017 IDLE: symbol_en=0 and symbol_out=00; on mod_req with the FIFO non-empty, go to PREAMBLE with pre_cnt=0, symbol_out=00, symbol_en=1, and do not pop.
REQ-018 IDLE with mod_req and an empty FIFO: remain in IDLE with outputs unchanged.
REQ-019 Preamble symbol k (k = 0..PREAMBLE_LEN-1) SHALL be 00 for even k and 10 for odd k.
REQ-020 PREAMBLE, mod_req, pre_cnt < PREAMBLE_LEN-1: increment pre_cnt and output preamble symbol pre_cnt+1.
REQ-021 PREAMBLE, mod_req, pre_cnt = PREAMBLE_LEN-1, FIFO non-empty: pop into hold register, set dibit_idx=0, output byte[7:6], go to DATA.
REQ-022 PREAMBLE, mod_req, pre_cnt = PREAMBLE_LEN-1, FIFO empty: pulse underrun, set symbol_en=0, go to IDLE.
REQ-023 DATA, mod_req, dibit_idx < 3: increment dibit_idx and output the next dibit, MSB first in the order [7:6], [5:4], [3:2], [1:0].
REQ-024 DATA, mod_req, dibit_idx = 3, held last flag = 1: set symbol_en=0 and symbol_out=00, go to IDLE.
REQ-025 DATA, mod_req, dibit_idx = 3, held last flag = 0, FIFO non-empty: pop the next byte, set dibit_idx=0 and output [7:6], with no gap symbol.
REQ-026 DATA, mod_req, dibit_idx = 3, held last flag = 0, FIFO empty: pulse underrun, set symbol_en=0, go to IDLE; a later byte starts a new frame with a full preamble.
REQ-027 A pop SHALL occur only on the mod_req edges named in REQ-021 and REQ-025; at most one pop per cycle.
REQ-028 Latency: a byte written to an empty FIFO in IDLE reaches symbol_out no earlier than PREAMBLE_LEN+1 mod_req pulses later.
REQ-029 mod_req held high on consecutive cycles SHALL advance one symbol per cycle; a push in the same cycle as an empty-check SHALL NOT be visible to that check.

Reset
REQ-030 On reset low, asynchronously: state=IDLE, FIFO empty (tx_ready=1), symbol_out=00, symbol_en=0, busy=0, underrun=0, pre_cnt=0, dibit_idx=0, hold register=0.
REQ-031 Reset mid-frame SHALL discard the FIFO and hold contents; the first mod_req after release with data present SHALL restart from the preamble.

Verification
REQ-032 Reset, then 5 mod_req pulses with no data -> symbol_en=0, busy=0, tx_ready=1 throughout.
REQ-033 Push 0xB4 with last=1, then issue mod_req pulses -> 16 preamble symbols 00,10,...,10, then 10,11,01,00, then symbol_en=0 and busy=0.
REQ-034 Push 0x1B (last=0), then 0xE4 (last=1) -> after the preamble: 00,01,10,11,11,10,01,00, with no idle gap between bytes.
REQ-035 Push 0x55 (last=0) only -> after the 4 data symbols, the next mod_req gives underrun=1 for one cycle and symbol_en=0.
REQ-036 Hold mod_req low and push 9 bytes with tx_valid held high -> tx_ready falls after the 8th byte; the 9th byte is accepted only after the first pop.
REQ-037 Assert reset during DATA, dibit_idx=2 -> outputs return immediately to REQ-030 values; after a new push, the next frame starts with preamble symbol 00.
